// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame compositor: phase encoding, write-source
// tags, screen-select values, default resolution and a constant clog2 helper.
// No logic; imported by every file of the compositor.
package vga_pkg;

    // Frame phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BG    = 3'd1,
        ST_DIG   = 3'd2,
        ST_CUR   = 3'd3,
        ST_DRAIN = 3'd4
    } phase_e;

    // Which colour source a pixel in the ROM-latency pipe takes at write time.
    typedef enum logic [1:0] {
        SRC_BG  = 2'd0,
        SRC_DIG = 2'd1,
        SRC_CUR = 2'd2
    } src_e;

    // Screen-select values driven by the game FSM.
    localparam int SCR_TITLE = 0;
    localparam int SCR_PLAY  = 1;
    localparam int SCR_OVER  = 2;
    localparam int SCR_SCORE = 3;

    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;

    // Ceiling log2 for sizing buses from parameters (value >= 2 expected).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: SCORE_W cycles from start to done; restarts on any start pulse.
// No backpressure; digits saturate to all-9 when value exceeds NUM_DIGITS digits.
// Ports: start (1-cycle pulse, latches value), value, done (high when idle),
//        digits (NUM_DIGITS BCD nibbles, most significant nibble on top).
module bin_to_bcd_seq
    import vga_pkg::*;
#(
    parameter int SCORE_W    = 12,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    iReset,
    input  logic                    start,
    input  logic [SCORE_W-1:0]      value,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits
);

    localparam int BW      = 4 * NUM_DIGITS;
    localparam int CW      = clog2(SCORE_W + 1);
    localparam int MAX_VAL = (10 ** NUM_DIGITS) - 1;

    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [BW-1:0]      adj;
    logic [63:0]        value_wide;

    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        value_wide = 64'(value);

        // Add-3 correction on every nibble that would overflow when doubled.
        adj = bcd_q;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
        end

        if (start) begin
            bin_d  = value;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            ovf_d  = value_wide > 64'(MAX_VAL);
        end else if (busy_q) begin
            bcd_d = {adj[BW-2:0], bin_q[SCORE_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(SCORE_W - 1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign done   = ~busy_q;
    assign digits = ovf_q ? {NUM_DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/vga_frame_compositor.sv
// Per-frame pixel-buffer writer: background copy, optional score digits, cursor.
// Latency: a write appears ROM_LAT+1 cycles after its ROM address; oBusy falls ROM_LAT cycles after the last write.
// No backpressure: one pixel issued per cycle; V_SYNC starts while busy are dropped.
// Ports: clk/iReset; V_SYNC, iScreenSel, iScore, iMouseX/Y from the game FSM;
//        oBgAddr/iBgData and oSprAddr/iSprData to the ROMs; x, y, color, writeEn to the
//        VGA adapter; oBusy frame-in-progress flag.
// Optional macro VGA_COMP_TRANSPARENT_EN adds KEY_COLOR: digit pixels of that colour are not written.
module vga_frame_compositor
    import vga_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int COLOR_W      = 3,
    parameter int SEL_W        = 2,
    parameter int SCORE_SCREEN = SCR_SCORE,
    parameter int SCORE_W      = 12,
    parameter int NUM_DIGITS   = 4,
    parameter int SPR_W        = 18,
    parameter int SPR_H        = 18,
    parameter int DIG_X0       = 120,
    parameter int DIG_Y0       = 155,
    parameter int DIG_PITCH    = 17,
    parameter int CUR_SIZE     = 4,
    parameter int CUR_COLOR    = 0,
    parameter int ROM_LAT      = 1
`ifdef VGA_COMP_TRANSPARENT_EN
    ,
    parameter int KEY_COLOR    = 3'b111
`endif
) (
    input  logic                                  clk,
    input  logic                                  iReset,
    input  logic                                  V_SYNC,
    input  logic [SEL_W-1:0]                      iScreenSel,
    input  logic [SCORE_W-1:0]                    iScore,
    input  logic [clog2(H_RES)-1:0]               iMouseX,
    input  logic [clog2(V_RES)-1:0]               iMouseY,
    output logic [clog2(H_RES*V_RES)-1:0]         oBgAddr,
    input  logic [COLOR_W-1:0]                    iBgData,
    output logic [clog2(10*SPR_W*SPR_H)-1:0]      oSprAddr,
    input  logic [COLOR_W-1:0]                    iSprData,
    output logic [clog2(H_RES)-1:0]               x,
    output logic [clog2(V_RES)-1:0]               y,
    output logic [COLOR_W-1:0]                    color,
    output logic                                  writeEn,
    output logic                                  oBusy
);

    localparam int XW   = clog2(H_RES);
    localparam int YW   = clog2(V_RES);
    localparam int BAW  = clog2(H_RES * V_RES);
    localparam int SAW  = clog2(10 * SPR_W * SPR_H);
    localparam int AREA = SPR_W * SPR_H;
    localparam int DW   = clog2(NUM_DIGITS + 1);
    localparam int DRW  = clog2(2 * ROM_LAT + 1);
    localparam int BCDW = 4 * NUM_DIGITS;

    phase_e             state_q, state_d;
    logic               vs_prev_q, vs_prev_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [XW-1:0]      mx_q, mx_d;
    logic [YW-1:0]      my_q, my_d;
    logic [XW-1:0]      cx_q, cx_d;
    logic [YW-1:0]      cy_q, cy_d;
    logic [XW-1:0]      digx_q, digx_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [BAW-1:0]     bg_addr_q, bg_addr_d;
    logic [SAW-1:0]     spr_addr_q, spr_addr_d;
    logic [DRW-1:0]     drain_q, drain_d;
    logic               busy_q, busy_d;

    // ROM-latency pipe: stage ROM_LAT-1 lines up with the ROM data bus.
    logic [ROM_LAT-1:0]           pv_q, pv_d;
    logic [ROM_LAT-1:0][XW-1:0]   px_q, px_d;
    logic [ROM_LAT-1:0][YW-1:0]   py_q, py_d;
    logic [ROM_LAT-1:0][1:0]      ps_q, ps_d;

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               wen_q, wen_d;

    logic               frame_start;
    logic               bcd_start;
    logic               bcd_done;
    logic [BCDW-1:0]    bcd_digits;
    logic               issue_vld;
    logic [XW-1:0]      issue_x;
    logic [YW-1:0]      issue_y;
    logic [1:0]         issue_src;
    logic [XW:0]        cur_x;
    logic [YW:0]        cur_y;
    logic               key_hit;

    bin_to_bcd_seq #(
        .SCORE_W   (SCORE_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .iReset(iReset),
        .start (bcd_start),
        .value (iScore),
        .done  (bcd_done),
        .digits(bcd_digits)
    );

    // First sprite-ROM address of digit k (k = 0 is the most significant digit).
    function automatic logic [SAW-1:0] digit_base(input logic [BCDW-1:0] bcd, input int k);
        logic [3:0] d;
        int         kk;
        kk = (k >= NUM_DIGITS) ? NUM_DIGITS - 1 : k;
        d  = bcd[(NUM_DIGITS-1-kk)*4 +: 4];
        return SAW'(int'(d) * AREA);
    endfunction

    always_comb begin
        state_d    = state_q;
        vs_prev_d  = V_SYNC;
        sel_d      = sel_q;
        mx_d       = mx_q;
        my_d       = my_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        digx_d     = digx_q;
        dig_d      = dig_q;
        bg_addr_d  = bg_addr_q;
        spr_addr_d = spr_addr_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        bcd_start  = 1'b0;
        issue_vld  = 1'b0;
        issue_x    = cx_q;
        issue_y    = cy_q;
        issue_src  = SRC_BG;
        cur_x      = {1'b0, mx_q} + {1'b0, cx_q};
        cur_y      = {1'b0, my_q} + {1'b0, cy_q};
        frame_start = vs_prev_q & ~V_SYNC;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    sel_d     = iScreenSel;
                    mx_d      = iMouseX;
                    my_d      = iMouseY;
                    bcd_start = 1'b1;
                    cx_d      = '0;
                    cy_d      = '0;
                    bg_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_BG;
                end
            end

            ST_BG: begin
                issue_vld = 1'b1;
                bg_addr_d = bg_addr_q + 1'b1;
                if (cx_q == XW'(H_RES - 1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(V_RES - 1)) begin
                        cy_d      = '0;
                        bg_addr_d = bg_addr_q;
                        if (sel_q == SEL_W'(SCORE_SCREEN)) begin
                            dig_d      = '0;
                            digx_d     = XW'(DIG_X0);
                            spr_addr_d = digit_base(bcd_digits, 0);
                            state_d    = ST_DIG;
                        end else begin
                            state_d = ST_CUR;
                        end
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end

            ST_DIG: begin
                // The background pass is far longer than the conversion, so
                // this gate only matters for degenerate parameter choices.
                issue_vld = bcd_done;
                issue_x   = digx_q + cx_q;
                issue_y   = YW'(DIG_Y0) + cy_q;
                issue_src = SRC_DIG;
                if (bcd_done) begin
                    spr_addr_d = spr_addr_q + 1'b1;
                    if (cx_q == XW'(SPR_W - 1)) begin
                        cx_d = '0;
                        if (cy_q == YW'(SPR_H - 1)) begin
                            cy_d = '0;
                            if (dig_q == DW'(NUM_DIGITS - 1)) begin
                                spr_addr_d = spr_addr_q;
                                state_d    = ST_CUR;
                            end else begin
                                dig_d      = dig_q + 1'b1;
                                digx_d     = digx_q + XW'(DIG_PITCH);
                                spr_addr_d = digit_base(bcd_digits, int'(dig_q) + 1);
                            end
                        end else begin
                            cy_d = cy_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end

            ST_CUR: begin
                // Off-screen cursor pixels still take a scan slot but never write.
                issue_vld = (cur_x < (XW+1)'(H_RES)) && (cur_y < (YW+1)'(V_RES));
                issue_x   = cur_x[XW-1:0];
                issue_y   = cur_y[YW-1:0];
                issue_src = SRC_CUR;
                if (cx_q == XW'(CUR_SIZE - 1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(CUR_SIZE - 1)) begin
                        cy_d    = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                // ROM_LAT+1 cycles retire the last write; oBusy then stays up
                // ROM_LAT more cycles past it before the engine re-arms.
                drain_d = drain_q + 1'b1;
                if (drain_q == DRW'(2 * ROM_LAT - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        pv_d[0] = issue_vld;
        px_d[0] = issue_x;
        py_d[0] = issue_y;
        ps_d[0] = issue_src;
        for (int i = 1; i < ROM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            px_d[i] = px_q[i-1];
            py_d[i] = py_q[i-1];
            ps_d[i] = ps_q[i-1];
        end

`ifdef VGA_COMP_TRANSPARENT_EN
        key_hit = (ps_q[ROM_LAT-1] == SRC_DIG) && (iSprData == COLOR_W'(KEY_COLOR));
`else
        key_hit = 1'b0;
`endif

        // Output stage: position and colour only change on an actual write.
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        wen_d   = pv_q[ROM_LAT-1] & ~key_hit;
        if (wen_d) begin
            x_d = px_q[ROM_LAT-1];
            y_d = py_q[ROM_LAT-1];
            case (ps_q[ROM_LAT-1])
                SRC_BG:  color_d = iBgData;
                SRC_DIG: color_d = iSprData;
                default: color_d = COLOR_W'(CUR_COLOR);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            vs_prev_q  <= 1'b0;
            sel_q      <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            digx_q     <= '0;
            dig_q      <= '0;
            bg_addr_q  <= '0;
            spr_addr_q <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            pv_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            ps_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_prev_q  <= vs_prev_d;
            sel_q      <= sel_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            digx_q     <= digx_d;
            dig_q      <= dig_d;
            bg_addr_q  <= bg_addr_d;
            spr_addr_q <= spr_addr_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            pv_q       <= pv_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ps_q       <= ps_d;
            x_q        <= x_d;
            y_q        <= y_d;
            color_q    <= color_d;
            wen_q      <= wen_d;
        end
    end

    assign oBgAddr  = bg_addr_q;
    assign oSprAddr = spr_addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign color    = color_q;
    assign writeEn  = wen_q;
    assign oBusy    = busy_q;

endmodule

// File: tb/tb_vga_frame_compositor.sv
// Directed bench for vga_frame_compositor on a reduced 32x16 screen with
// 4x3 digit sprites, 8-bit colour and two-cycle ROMs modelled locally.
module tb_vga_frame_compositor;

    localparam int H   = 32;
    localparam int V   = 16;
    localparam int CW  = 8;
    localparam int SW  = 14;
    localparam int ND  = 4;
    localparam int SPW = 4;
    localparam int SPH = 3;
    localparam int DX0 = 5;
    localparam int DY0 = 6;
    localparam int DP  = 3;
    localparam int CS  = 4;
    localparam int CC  = 165;
    localparam int LAT = 2;

    typedef struct packed {
        logic [4:0] px;
        logic [3:0] py;
        logic [7:0] pc;
    } pix_t;

    logic        clk = 1'b0;
    logic        iReset;
    logic        V_SYNC;
    logic [1:0]  iScreenSel;
    logic [13:0] iScore;
    logic [4:0]  iMouseX;
    logic [3:0]  iMouseY;
    logic [8:0]  oBgAddr;
    logic [7:0]  iBgData;
    logic [6:0]  oSprAddr;
    logic [7:0]  iSprData;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [7:0]  color;
    logic        writeEn;
    logic        oBusy;

    logic [7:0]  bg_p  [LAT];
    logic [7:0]  spr_p [LAT];

    pix_t wq[$];
    pix_t eq[$];
    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   fall_cyc = 0;
    int   frames_started = 0;
    bit   busy_prev = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_frame_compositor #(
        .H_RES(H), .V_RES(V), .COLOR_W(CW), .SEL_W(2), .SCORE_SCREEN(3),
        .SCORE_W(SW), .NUM_DIGITS(ND), .SPR_W(SPW), .SPR_H(SPH),
        .DIG_X0(DX0), .DIG_Y0(DY0), .DIG_PITCH(DP), .CUR_SIZE(CS),
        .CUR_COLOR(CC), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iScreenSel(iScreenSel),
        .iScore(iScore), .iMouseX(iMouseX), .iMouseY(iMouseY),
        .oBgAddr(oBgAddr), .iBgData(iBgData), .oSprAddr(oSprAddr),
        .iSprData(iSprData), .x(x), .y(y), .color(color),
        .writeEn(writeEn), .oBusy(oBusy)
    );

    function automatic int bg_rom(input int a);
        return ((a * 37) ^ (a >> 3)) & 255;
    endfunction

    function automatic int spr_rom(input int a);
        return (a * 3 + 17) & 255;
    endfunction

    function automatic pix_t mk(input int px, input int py, input int pc);
        pix_t p;
        p.px = 5'(px);
        p.py = 4'(py);
        p.pc = 8'(pc);
        return p;
    endfunction

    // ROM models: data for an address appears LAT cycles after it.
    always @(posedge clk) begin
        bg_p[0]  <= 8'(bg_rom(int'(oBgAddr)));
        spr_p[0] <= 8'(spr_rom(int'(oSprAddr)));
        for (int i = 1; i < LAT; i++) begin
            bg_p[i]  <= bg_p[i-1];
            spr_p[i] <= spr_p[i-1];
        end
        cyc <= cyc + 1;
    end
    assign iBgData  = bg_p[LAT-1];
    assign iSprData = spr_p[LAT-1];

    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            wq.push_back(mk(int'(x), int'(y), int'(color)));
            last_wr_cyc = cyc;
        end
        if (busy_prev && oBusy === 1'b0) fall_cyc = cyc;
        if (!busy_prev && oBusy === 1'b1) frames_started++;
        busy_prev = (oBusy === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input int sel, input int score, input int mx, input int my);
        int dv[ND];
        eq.delete();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                eq.push_back(mk(c, r, bg_rom(r * H + c)));
        if (sel == 3) begin
            for (int k = 0; k < ND; k++)
                dv[k] = (score > 9999) ? 9 : (score / (10 ** (ND - 1 - k))) % 10;
            for (int k = 0; k < ND; k++)
                for (int r = 0; r < SPH; r++)
                    for (int c = 0; c < SPW; c++)
                        eq.push_back(mk(DX0 + DP * k + c, DY0 + r,
                                        spr_rom(dv[k] * SPW * SPH + r * SPW + c)));
        end
        for (int dy = 0; dy < CS; dy++)
            for (int dx = 0; dx < CS; dx++)
                if (mx + dx < H && my + dy < V) eq.push_back(mk(mx + dx, my + dy, CC));
    endtask

    task automatic compare_frame(input string tag);
        int bad;
        bad = 0;
        check({tag, "_count"}, 64'(wq.size()), 64'(eq.size()));
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            if (wq[i] !== eq[i]) bad++;
            check($sformatf("%s_pix%0d", tag, i), 64'(wq[i]), 64'(eq[i]));
            if (bad >= 5) break;
        end
    endtask

    task automatic run_frame(input int sel, input int score, input int mx, input int my,
                             input int glitch_at, input string tag);
        int fs0;
        int n;
        bit ok;
        @(negedge clk);
        iScreenSel = 2'(sel);
        iScore     = 14'(score);
        iMouseX    = 5'(mx);
        iMouseY    = 4'(my);
        wq.delete();
        fs0    = frames_started;
        V_SYNC = 1'b0;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            if (glitch_at > 0 && n == glitch_at) begin
                V_SYNC     = 1'b1;
                iScreenSel = ~2'(sel);
                iScore     = 14'd5;
                iMouseX    = 5'd0;
                iMouseY    = 4'd0;
            end
            if (glitch_at > 0 && n == glitch_at + 1) V_SYNC = 1'b0;
            if (n > 2 && oBusy === 1'b0) ok = 1'b1;
        end
        check({tag, "_done"}, 64'(ok), 64'd1);
        V_SYNC = 1'b1;
        @(negedge clk);
        check({tag, "_frames"}, 64'(frames_started - fs0), 64'd1);
        build_exp(sel, score, mx, my);
        compare_frame(tag);
    endtask

    initial begin
        iReset     = 1'b1;
        V_SYNC     = 1'b1;
        iScreenSel = '0;
        iScore     = '0;
        iMouseX    = '0;
        iMouseY    = '0;
        repeat (2) @(posedge clk);

        // Reset held: V_SYNC edges must not start anything.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            V_SYNC = ~V_SYNC;
            check("rst_wen", 64'(writeEn), 64'd0);
            check("rst_busy", 64'(oBusy), 64'd0);
            check("rst_x", 64'(x), 64'd0);
            check("rst_y", 64'(y), 64'd0);
        end
        @(negedge clk);
        iReset = 1'b0;
        V_SYNC = 1'b1;
        repeat (3) @(negedge clk);

        // Plain screen: background then 16 cursor pixels, no digits.
        run_frame(1, 0, 10, 3, 0, "plain");
        check("plain_len", 64'(wq.size()), 64'd528);
        check("plain_busy_tail", 64'(fall_cyc - last_wr_cyc), 64'(LAT));

        // Score 1234: digit 1 base address 12, digit 4 base address 48 at x=14.
        run_frame(3, 1234, 20, 12, 0, "s1234");
        check("s1234_len", 64'(wq.size()), 64'd576);
        check("s1234_dig0", 64'(wq[512]), 64'(mk(5, 6, spr_rom(12))));
        check("s1234_dig3", 64'(wq[548]), 64'(mk(14, 6, spr_rom(48))));
        check("s1234_busy_tail", 64'(fall_cyc - last_wr_cyc), 64'(LAT));

        // Saturation: 16383 does not fit four digits, all drawn as 9 (base 108).
        run_frame(3, 16383, 0, 0, 0, "sat");
        check("sat_dig0", 64'(wq[512]), 64'(mk(5, 6, spr_rom(108))));
        check("sat_dig3", 64'(wq[548]), 64'(mk(14, 6, spr_rom(108))));

        // Largest representable score, cursor touching the bottom-right corner.
        run_frame(3, 9999, 28, 12, 0, "s9999");

        // Cursor mostly off-screen: only (30,15) and (31,15) written.
        run_frame(0, 0, 30, 15, 0, "edge");
        check("edge_len", 64'(wq.size()), 64'd514);
        check("edge_c0", 64'(wq[512]), 64'(mk(30, 15, CC)));
        check("edge_c1", 64'(wq[513]), 64'(mk(31, 15, CC)));

        // Second V_SYNC edge and input changes mid-frame are ignored.
        run_frame(1, 77, 3, 4, 100, "glitch");

        // Reset in the middle of the background pass.
        @(negedge clk);
        iScreenSel = 2'd1;
        V_SYNC     = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_busy", 64'(oBusy), 64'd1);
        iReset = 1'b1;
        @(negedge clk);
        check("mid_rst_wen", 64'(writeEn), 64'd0);
        check("mid_rst_busy", 64'(oBusy), 64'd0);
        check("mid_rst_x", 64'(x), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        iReset = 1'b0;
        V_SYNC = 1'b1;
        wq.delete();
        repeat (10) @(negedge clk);
        check("mid_quiet", 64'(wq.size()), 64'd0);

        run_frame(1, 0, 0, 0, 0, "restart");
        check("restart_first", 64'(wq[0]), 64'(mk(0, 0, bg_rom(0))));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
